// File: rtl/commit_trace_unit.sv
// Commit/trace producer: captures each retired instruction as a normalised record, buffers it
// in a small FIFO for the trace sink, and tracks cycle/instret counts and end-of-test draining.
module commit_trace_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned OP_W       = 6,
    parameter logic [31:0] HALT_INSTR = 32'h0000006f
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            wb_valid_i,
    input  logic [XLEN-1:0] wb_pc_i,
    input  logic [31:0]     wb_instr_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_rd_data_i,
    input  logic            wb_rf_we_i,
    input  logic            wb_mem_re_i,
    input  logic            wb_mem_we_i,
    input  logic [XLEN-1:0] wb_mem_addr_i,
    input  logic [XLEN-1:0] wb_mem_wdata_i,
    input  logic [OP_W-1:0] wb_op_i,
    output logic            stall_o,
    output logic            trace_valid_o,
    input  logic            trace_ready_i,
    output logic [XLEN-1:0] trace_pc_o,
    output logic [31:0]     trace_instr_o,
    output logic [4:0]      trace_rd_o,
    output logic [XLEN-1:0] trace_rd_data_o,
    output logic [XLEN-1:0] trace_mem_addr_o,
    output logic [XLEN-1:0] trace_mem_wdata_o,
    output logic [OP_W-1:0] trace_op_o,
    output logic            trace_rf_we_o,
    output logic            trace_mem_re_o,
    output logic            trace_mem_we_o,
    output logic [63:0]     cycle_count_o,
    output logic [63:0]     instret_o,
    output logic            halted_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_data;
        logic            rf_we;
        logic            mem_re;
        logic            mem_we;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_wdata;
        logic [OP_W-1:0] op;
    } rec_t;

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e           state_q;
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic [63:0]      cycle_q;
    logic [63:0]      instret_q;
    logic             halted_q;
    rec_t             mem_q [DEPTH];

    rec_t rec_d;
    rec_t head;
    logic push;
    logic pop;
    logic kill_rd;

    assign trace_valid_o = (count_q != '0);
    // No push-through: a full FIFO stalls even if the head is popped this cycle.
    assign stall_o       = (count_q == CNT_W'(DEPTH)) || (state_q != StRun);
    assign push          = wb_valid_i && !stall_o;
    assign pop           = trace_valid_o && trace_ready_i;

    // Normalise at push so the sink never sees stale or meaningless fields.
    always_comb begin
        rec_d           = '0;
        kill_rd         = wb_mem_we_i || !wb_rf_we_i || (wb_rd_i == 5'd0);
        rec_d.pc        = wb_pc_i;
        rec_d.instr     = wb_instr_i;
        rec_d.op        = wb_op_i;
        rec_d.mem_we    = wb_mem_we_i;
        rec_d.mem_re    = wb_mem_re_i && !wb_mem_we_i;
        rec_d.rf_we     = !kill_rd;
        rec_d.rd        = kill_rd ? 5'd0 : wb_rd_i;
        rec_d.rd_data   = kill_rd ? '0 : wb_rd_data_i;
        rec_d.mem_addr  = (wb_mem_re_i || wb_mem_we_i) ? wb_mem_addr_i : '0;
        rec_d.mem_wdata = wb_mem_we_i ? wb_mem_wdata_i : '0;
    end

    always_comb begin
        head = '0;
        if (trace_valid_o) begin
            head = mem_q[rptr_q];
        end
    end

    assign trace_pc_o        = head.pc;
    assign trace_instr_o     = head.instr;
    assign trace_rd_o        = head.rd;
    assign trace_rd_data_o   = head.rd_data;
    assign trace_rf_we_o     = head.rf_we;
    assign trace_mem_re_o    = head.mem_re;
    assign trace_mem_we_o    = head.mem_we;
    assign trace_mem_addr_o  = head.mem_addr;
    assign trace_mem_wdata_o = head.mem_wdata;
    assign trace_op_o        = head.op;
    assign cycle_count_o     = cycle_q;
    assign instret_o         = instret_q;
    assign halted_o          = halted_q;

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= rec_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= StRun;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            case (state_q)
                StRun: begin
                    if (push && (wb_instr_i == HALT_INSTR)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (count_q == '0) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                    end
                end
                StHalted: state_q <= StHalted;
                default:  state_q <= StRun;
            endcase

            if ((state_q != StHalted) && (cycle_q != '1)) begin
                cycle_q <= cycle_q + 64'd1;
            end
            if (push && (wb_pc_i != '0) && (instret_q != '1)) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed bench for commit_trace_unit: hand-computed expectations checked with immediate asserts.
module tb_commit_trace_unit;

    logic        clk;
    logic        rstn;
    logic        wb_valid_i;
    logic [31:0] wb_pc_i;
    logic [31:0] wb_instr_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_rd_data_i;
    logic        wb_rf_we_i;
    logic        wb_mem_re_i;
    logic        wb_mem_we_i;
    logic [31:0] wb_mem_addr_i;
    logic [31:0] wb_mem_wdata_i;
    logic [5:0]  wb_op_i;
    logic        stall_o;
    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_pc_o;
    logic [31:0] trace_instr_o;
    logic [4:0]  trace_rd_o;
    logic [31:0] trace_rd_data_o;
    logic [31:0] trace_mem_addr_o;
    logic [31:0] trace_mem_wdata_o;
    logic [5:0]  trace_op_o;
    logic        trace_rf_we_o;
    logic        trace_mem_re_o;
    logic        trace_mem_we_o;
    logic [63:0] cycle_count_o;
    logic [63:0] instret_o;
    logic        halted_o;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] edges = 0;
    logic        halt_model = 1'b0;

    commit_trace_unit dut (
        .clk               (clk),
        .rstn              (rstn),
        .wb_valid_i        (wb_valid_i),
        .wb_pc_i           (wb_pc_i),
        .wb_instr_i        (wb_instr_i),
        .wb_rd_i           (wb_rd_i),
        .wb_rd_data_i      (wb_rd_data_i),
        .wb_rf_we_i        (wb_rf_we_i),
        .wb_mem_re_i       (wb_mem_re_i),
        .wb_mem_we_i       (wb_mem_we_i),
        .wb_mem_addr_i     (wb_mem_addr_i),
        .wb_mem_wdata_i    (wb_mem_wdata_i),
        .wb_op_i           (wb_op_i),
        .stall_o           (stall_o),
        .trace_valid_o     (trace_valid_o),
        .trace_ready_i     (trace_ready_i),
        .trace_pc_o        (trace_pc_o),
        .trace_instr_o     (trace_instr_o),
        .trace_rd_o        (trace_rd_o),
        .trace_rd_data_o   (trace_rd_data_o),
        .trace_mem_addr_o  (trace_mem_addr_o),
        .trace_mem_wdata_o (trace_mem_wdata_o),
        .trace_op_o        (trace_op_o),
        .trace_rf_we_o     (trace_rf_we_o),
        .trace_mem_re_o    (trace_mem_re_o),
        .trace_mem_we_o    (trace_mem_we_o),
        .cycle_count_o     (cycle_count_o),
        .instret_o         (instret_o),
        .halted_o          (halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; the bench tracks the expected cycle count alongside.
    task automatic tick();
        @(posedge clk);
        if (!rstn) edges = 0;
        else if (!halt_model) edges = edges + 1;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                          input logic [31:0] data, input logic rfwe, input logic re,
                          input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [5:0] op);
        wb_valid_i     = 1'b1;
        wb_pc_i        = pc;
        wb_instr_i     = instr;
        wb_rd_i        = rd;
        wb_rd_data_i   = data;
        wb_rf_we_i     = rfwe;
        wb_mem_re_i    = re;
        wb_mem_we_i    = we;
        wb_mem_addr_i  = addr;
        wb_mem_wdata_i = wdata;
        wb_op_i        = op;
    endtask

    // addi x5, x0, 0x11 with junk on the memory inputs that must be cleared.
    task automatic alu(input logic [31:0] pc);
        retire(pc, 32'h01100293, 5'd5, 32'h11, 1'b1, 1'b0, 1'b0, 32'habc, 32'h99, 6'd1);
    endtask

    initial begin
        rstn          = 1'b0;
        trace_ready_i = 1'b0;
        retire(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_valid_i    = 1'b0;
        tick();
        tick();
        chk("rst_valid", trace_valid_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_halted", halted_o, 0);
        chk("rst_cycle", cycle_count_o, 0);
        chk("rst_instret", instret_o, 0);
        chk("rst_pc", trace_pc_o, 0);
        rstn = 1'b1;

        // Three back-to-back ALU retires, sink always ready.
        trace_ready_i = 1'b1;
        alu(32'h80000000);
        tick();
        chk("t1_valid", trace_valid_o, 1);
        chk("t1_pc0", trace_pc_o, 32'h80000000);
        chk("t1_instr", trace_instr_o, 32'h01100293);
        chk("t1_rd", trace_rd_o, 5);
        chk("t1_rd_data", trace_rd_data_o, 32'h11);
        chk("t1_rf_we", trace_rf_we_o, 1);
        chk("t1_addr_clr", trace_mem_addr_o, 0);
        chk("t1_wdata_clr", trace_mem_wdata_o, 0);
        chk("t1_op", trace_op_o, 1);
        alu(32'h80000004);
        tick();
        chk("t1_pc1", trace_pc_o, 32'h80000004);
        alu(32'h80000008);
        tick();
        chk("t1_pc2", trace_pc_o, 32'h80000008);
        wb_valid_i = 1'b0;
        tick();
        chk("t1_empty", trace_valid_o, 0);
        chk("t1_instret", instret_o, 3);
        chk("t1_cycle", cycle_count_o, edges);

        // Fill to DEPTH with sink blocked; ninth retire must wait.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            alu(32'h100 + 32'(4 * i));
            tick();
        end
        chk("t2_stall_full", stall_o, 1);
        chk("t2_head", trace_pc_o, 32'h100);
        alu(32'h120);
        tick();
        chk("t2_still_stall", stall_o, 1);
        chk("t2_instret_held", instret_o, 11);
        trace_ready_i = 1'b1;
        tick();
        chk("t2_stall_free", stall_o, 0);
        chk("t2_head1", trace_pc_o, 32'h104);
        tick();
        wb_valid_i = 1'b0;
        chk("t2_instret", instret_o, 12);
        for (int j = 2; j <= 8; j++) begin
            chk("t2_order", trace_pc_o, 32'h100 + 32'(4 * j));
            tick();
        end
        chk("t2_empty", trace_valid_o, 0);

        // Store (with illegal re+we): rd cleared, re cleared, address/data kept.
        retire(32'h80000010, 32'h0072a023, 5'd7, 32'h55, 1'b1, 1'b1, 1'b1, 32'h80002000,
               32'hdeadbeef, 6'd9);
        tick();
        wb_valid_i = 1'b0;
        chk("st_rd", trace_rd_o, 0);
        chk("st_rd_data", trace_rd_data_o, 0);
        chk("st_rf_we", trace_rf_we_o, 0);
        chk("st_mem_we", trace_mem_we_o, 1);
        chk("st_mem_re", trace_mem_re_o, 0);
        chk("st_addr", trace_mem_addr_o, 32'h80002000);
        chk("st_wdata", trace_mem_wdata_o, 32'hdeadbeef);
        tick();
        // Load: address kept, store data cleared.
        retire(32'h80000014, 32'h0002a183, 5'd3, 32'h77, 1'b1, 1'b1, 1'b0, 32'h80002004,
               32'h1234, 6'd8);
        tick();
        wb_valid_i = 1'b0;
        chk("ld_rd", trace_rd_o, 3);
        chk("ld_mem_re", trace_mem_re_o, 1);
        chk("ld_addr", trace_mem_addr_o, 32'h80002004);
        chk("ld_wdata", trace_mem_wdata_o, 0);
        tick();
        // pc == 0 is not counted as retired.
        retire(32'h0, 32'h00000013, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 6'd1);
        tick();
        wb_valid_i = 1'b0;
        chk("pc0_valid", trace_valid_o, 1);
        chk("pc0_instret", instret_o, 14);
        tick();

        // Simultaneous push/pop at count 4 for 20 cycles, wrapping the pointers.
        trace_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alu(32'h200 + 32'(4 * i));
            tick();
        end
        trace_ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            alu(32'h200 + 32'(4 * (4 + k)));
            tick();
            chk("t5_head", trace_pc_o, 32'h200 + 32'(4 * (k + 1)));
        end
        wb_valid_i = 1'b0;
        chk("t5_stall", stall_o, 0);
        for (int j = 20; j < 24; j++) begin
            chk("t5_tail", trace_pc_o, 32'h200 + 32'(4 * j));
            tick();
        end
        chk("t5_empty", trace_valid_o, 0);
        chk("t5_instret", instret_o, 38);

        // End of test with two older records pending.
        trace_ready_i = 1'b0;
        alu(32'h300);
        tick();
        alu(32'h304);
        tick();
        retire(32'h308, 32'h0000006f, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'd2);
        tick();
        alu(32'h30c);
        chk("h_stall", stall_o, 1);
        chk("h_not_halted", halted_o, 0);
        chk("h_head", trace_pc_o, 32'h300);
        tick();
        chk("h_ignored", instret_o, 41);
        trace_ready_i = 1'b1;
        tick();
        chk("h_pop1", trace_pc_o, 32'h304);
        tick();
        chk("h_pop2", trace_pc_o, 32'h308);
        chk("h_instr", trace_instr_o, 32'h0000006f);
        tick();
        chk("h_drained", trace_valid_o, 0);
        chk("h_drain_wait", halted_o, 0);
        tick();
        halt_model = 1'b1;
        chk("h_halted", halted_o, 1);
        chk("h_cycle", cycle_count_o, edges);
        tick();
        tick();
        tick();
        chk("h_frozen", cycle_count_o, edges);
        chk("h_still_halted", halted_o, 1);
        chk("h_still_stall", stall_o, 1);
        chk("h_instret", instret_o, 41);

        // Reset out of HALTED, buffer 5 records in DRAIN, then reset again.
        wb_valid_i = 1'b0;
        rstn       = 1'b0;
        tick();
        rstn       = 1'b1;
        halt_model = 1'b0;
        chk("r_left_halt", halted_o, 0);
        trace_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alu(32'h400 + 32'(4 * i));
            tick();
        end
        retire(32'h410, 32'h0000006f, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 6'd2);
        tick();
        wb_valid_i = 1'b0;
        chk("r_drain_stall", stall_o, 1);
        chk("r_instret5", instret_o, 5);
        rstn = 1'b0;
        tick();
        chk("r_valid", trace_valid_o, 0);
        chk("r_stall", stall_o, 0);
        chk("r_halted", halted_o, 0);
        chk("r_cycle", cycle_count_o, 0);
        chk("r_instret", instret_o, 0);
        chk("r_pc", trace_pc_o, 0);
        rstn          = 1'b1;
        trace_ready_i = 1'b1;
        alu(32'h500);
        tick();
        wb_valid_i = 1'b0;
        chk("r_run_valid", trace_valid_o, 1);
        chk("r_run_pc", trace_pc_o, 32'h500);
        chk("r_run_instret", instret_o, 1);
        chk("r_run_cycle", cycle_count_o, edges);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_trace_unit.md
Name: commit_trace_unit

Overview:
- Producer side of the commit/trace interface consumed by the simulation logger and the CPI counters.
- Sits after the writeback stage of the core and captures each retired (non-flushed) instruction as one commit record.
- Buffers records in a small FIFO and presents them to a trace sink over a valid/ready handshake, back-pressuring the pipeline when full.
- Keeps cycle and retired-instruction counters, detects the end-of-test self-loop and drains the buffer before halting.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- OP_W, 6, width of the encoded operation field (riscv_pkg operation_e).
- HALT_INSTR, 32'h0000006f, instruction word that marks end of test.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- wb_valid_i  in  1  retiring instruction present; held stable until accepted
- wb_pc_i  in  XLEN  PC of the retiring instruction
- wb_instr_i  in  32  instruction word
- wb_rd_i  in  5  destination register
- wb_rd_data_i  in  XLEN  writeback value
- wb_rf_we_i  in  1  register-file write enable
- wb_mem_re_i  in  1  load
- wb_mem_we_i  in  1  store
- wb_mem_addr_i  in  XLEN  load/store effective address
- wb_mem_wdata_i  in  XLEN  store data
- wb_op_i  in  OP_W  decoded operation
- stall_o  out  1  pipeline must hold writeback
- trace_valid_o  out  1  record available at FIFO head
- trace_ready_i  in  1  sink accepts record
- trace_pc_o, trace_instr_o, trace_rd_o, trace_rd_data_o, trace_mem_addr_o, trace_mem_wdata_o, trace_op_o  out  as inputs  head record fields
- trace_rf_we_o, trace_mem_re_o, trace_mem_we_o  out  1 each  head record flags
- cycle_count_o  out  64  cycles since reset, excluding HALTED
- instret_o  out  64  accepted records with pc != 0
- halted_o  out  1  end of test reached and FIFO drained

Behaviour:
- Reset (rstn=0 at posedge clk): FIFO emptied; count=0; state=RUN; all trace_* outputs 0; trace_valid_o=0; stall_o=0; counters 0; halted_o=0. Reset mid-operation discards buffered records without emitting them.
- Accept: push = wb_valid_i && !stall_o. stall_o = (count==DEPTH) || state!=RUN. No push-through at full, even when a pop occurs in the same cycle.
- Pop: trace_valid_o && trace_ready_i. trace_valid_o = (count!=0). Head fields are driven from registered storage.
- Latency: a record pushed at edge N is visible at the head after edge N when the FIFO was empty. Order is preserved.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- Record normalisation, applied at push:
  - if wb_mem_we_i, or !wb_rf_we_i, or wb_rd_i==0: stored rd=0, rd_data=0, rf_we=0.
  - if !wb_mem_re_i && !wb_mem_we_i: stored mem_addr=0.
  - if !wb_mem_we_i: stored mem_wdata=0.
  - wb_mem_re_i && wb_mem_we_i together is illegal; store wins and re is cleared.
- States:
  - RUN: normal operation. A push with wb_instr_i==HALT_INSTR still pushes that record, then goes to DRAIN.
  - DRAIN: stall_o=1 and wb_valid_i is ignored. Pops continue. When count==0, go to HALTED.
  - HALTED: halted_o=1; stall_o=1; counters frozen. Left only by reset.
- cycle_count_o: +1 on every non-reset edge in RUN or DRAIN; saturates at all-ones.
- instret_o: +1 on each push with wb_pc_i != 0; saturates.

Test Plan:
- Reset, then 3 back-to-back retires (pc 0x80000000/04/08, addi x5=0x11) with trace_ready_i=1 -> 3 records in order, each 1 cycle after push; instret_o=3.
- trace_ready_i=0 with 9 retires at DEPTH=8 -> stall_o=1 after the 8th accept; 9th held; after one pop the 9th is accepted; all 9 emerge in order.
- Store sw to 0x80002000 data 0xdeadbeef with wb_rd_i=7 and rf_we=1 -> record has rd=0, rd_data=0, mem_we=1, addr 0x80002000, wdata 0xdeadbeef.
- Push 0x0000006f with 2 older records pending and ready=0 -> DRAIN, stall_o=1; release ready -> 3 pops, then halted_o=1 and cycle_count_o frozen.
- Push and pop in the same cycle at count=4 -> count stays 4; sustain for 20 cycles to exercise pointer wrap; data integrity holds.
- Assert rstn=0 with 5 records buffered in DRAIN -> next cycle trace_valid_o=0, state RUN, counters 0, halted_o=0.
